pe_m_seq: RTL and testbench

//  Next-gen multi-mode systolic PE. GEMM mode: pipelined MAC with pass-through of

---
 rtl/pe_m_seq_if.sv | 37 +++
 rtl/pe_m_seq.sv | 187 ++++++++++++++++++
 tb/tb_pe_m_seq.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_m_seq_if.sv
// Operand/result bundle of one systolic PE; the array side uses master,
// the PE itself uses slave.
interface pe_m_seq_if #(
  parameter int MUL_BW = 16,
  parameter int ACC_BW = 32,
  parameter int ITER_W = 4
);
  logic [1:0]        mode_i;
  logic              start_i;
  logic [ITER_W-1:0] iter_num_i;
  logic              valid_i;
  logic [ACC_BW-1:0] mac_i;
  logic [MUL_BW-1:0] var_i;
  logic [MUL_BW-1:0] x_i;
  logic [MUL_BW-1:0] wc_i;
  logic [ACC_BW-1:0] o_i;

  logic [ACC_BW-1:0] mac_o;
  logic [ACC_BW-1:0] o_o;
  logic [MUL_BW-1:0] var_o;
  logic [MUL_BW-1:0] x_o;
  logic [MUL_BW-1:0] wc_o;
  logic              valid_o;
  logic              busy_o;
  logic              done_o;
  logic              sat_o;

  modport master (
    output mode_i, start_i, iter_num_i, valid_i, mac_i, var_i, x_i, wc_i, o_i,
    input  mac_o, o_o, var_o, x_o, wc_o, valid_o, busy_o, done_o, sat_o
  );

  modport slave (
    input  mode_i, start_i, iter_num_i, valid_i, mac_i, var_i, x_i, wc_i, o_i,
    output mac_o, o_o, var_o, x_o, wc_o, valid_o, busy_o, done_o, sat_o
  );
endinterface

// File: rtl/pe_m_seq.sv
// Multi-mode systolic PE: pipelined GEMM MAC plus Horner-iterated unary ops.
// Define ACC_SAT_EN to saturate the final accumulator add instead of wrapping.
//
// state  | meaning
// IDLE   | GEMM pass-through active, waiting for a unary start
// ITER   | one Horner step per cycle, cnt counts remaining steps
// DONE   | unary result in oreg, done_o high for this cycle
module pe_m_seq #(
  parameter int INT_BW = 5,
  parameter int FRA_BW = 10,
  parameter int MUL_BW = 16,
  parameter int ACC_BW = 32,
  parameter int ITER_W = 4
) (
  input logic         clk,
  input logic         rst_n,
  pe_m_seq_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;

  localparam int SAT_SH = INT_BW + 2*FRA_BW;
  localparam logic signed [ACC_BW-1:0] SAT_HI = ACC_BW'((64'sd1 <<< SAT_SH) - 64'sd1);
  localparam logic signed [ACC_BW-1:0] SAT_LO = ACC_BW'(-(64'sd1 <<< SAT_SH));
  localparam logic signed [MUL_BW-1:0] MUL_MAX = {1'b0, {(MUL_BW-1){1'b1}}};
  localparam logic signed [MUL_BW-1:0] MUL_MIN = {1'b1, {(MUL_BW-1){1'b0}}};

  state_t                    state_q, state_d;
  logic [ITER_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_BW-1:0]  oreg_q, oreg_d;
  logic [MUL_BW-1:0]         vreg_q, vreg_d;
  logic [MUL_BW-1:0]         ireg_q, ireg_d;
  logic [MUL_BW-1:0]         wreg_q, wreg_d;
  logic                      pend_q, pend_d;
  logic                      valid_q, valid_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      sat_q, sat_d;

  logic signed [MUL_BW-1:0]   fb;
  logic                       fb_sat;
  logic signed [MUL_BW-1:0]   mul_a, mul_b;
  logic signed [2*MUL_BW-1:0] prod;
  logic signed [ACC_BW-1:0]   prod_ext;
  logic signed [ACC_BW-1:0]   addend;
  logic signed [ACC_BW-1:0]   sum;
  logic                       add_sat;
  logic                       start_ok;

  // Feedback narrowing of oreg back to a Q(INT_BW).(FRA_BW) multiplier operand.
  always_comb begin
    fb     = oreg_q[FRA_BW+MUL_BW-1:FRA_BW];
    fb_sat = 1'b0;
    if (oreg_q > SAT_HI) begin
      fb     = MUL_MAX;
      fb_sat = 1'b1;
    end else if (oreg_q < SAT_LO) begin
      fb     = MUL_MIN;
      fb_sat = 1'b1;
    end
  end

  // One shared multiplier/adder: Horner step while iterating, GEMM MAC otherwise.
  always_comb begin
    if (state_q == S_ITER) begin
      mul_a  = fb;
      mul_b  = $signed(vreg_q);
      addend = ACC_BW'($signed(bus.wc_i)) <<< FRA_BW;
    end else begin
      mul_a  = $signed(wreg_q);
      mul_b  = $signed(ireg_q);
      addend = $signed(bus.o_i);
    end
  end

  assign prod     = mul_a * mul_b;
  assign prod_ext = ACC_BW'(prod);

`ifdef ACC_SAT_EN
  logic [ACC_BW:0] sum_wide;

  always_comb begin
    sum_wide = {prod_ext[ACC_BW-1], prod_ext} + {addend[ACC_BW-1], addend};
    add_sat  = (sum_wide[ACC_BW] != sum_wide[ACC_BW-1]);
    if (!add_sat)
      sum = sum_wide[ACC_BW-1:0];
    else if (sum_wide[ACC_BW])
      sum = {1'b1, {(ACC_BW-1){1'b0}}};
    else
      sum = {1'b0, {(ACC_BW-1){1'b1}}};
  end
`else
  always_comb begin
    sum     = prod_ext + addend;
    add_sat = 1'b0;
  end
`endif

  assign start_ok = bus.start_i && (bus.mode_i != 2'b00);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    oreg_d  = oreg_q;
    vreg_d  = vreg_q;
    ireg_d  = ireg_q;
    wreg_d  = wreg_q;
    pend_d  = 1'b0;
    valid_d = 1'b0;
    sat_d   = sat_q;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          // A pending GEMM result is dropped: the unary seed owns oreg now.
          vreg_d  = bus.var_i;
          oreg_d  = $signed(bus.mac_i);
          cnt_d   = bus.iter_num_i;
          sat_d   = 1'b0;
          state_d = (bus.iter_num_i == '0) ? S_DONE : S_ITER;
        end else begin
          if (pend_q) begin
            oreg_d  = sum;
            valid_d = 1'b1;
            if (add_sat) sat_d = 1'b1;
          end
          if (bus.valid_i && (bus.mode_i == 2'b00)) begin
            wreg_d = bus.wc_i;
            ireg_d = bus.x_i;
            vreg_d = bus.var_i;
            pend_d = 1'b1;
          end
        end
      end
      S_ITER: begin
        oreg_d = sum;
        if (fb_sat || add_sat) sat_d = 1'b1;
        if (cnt_q == ITER_W'(1))
          state_d = S_DONE;
        else
          cnt_d = cnt_q - ITER_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      oreg_q  <= '0;
      vreg_q  <= '0;
      ireg_q  <= '0;
      wreg_q  <= '0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      oreg_q  <= oreg_d;
      vreg_q  <= vreg_d;
      ireg_q  <= ireg_d;
      wreg_q  <= wreg_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sat_q   <= sat_d;
    end
  end

  assign bus.mac_o   = oreg_q;
  assign bus.o_o     = oreg_q;
  assign bus.var_o   = vreg_q;
  assign bus.x_o     = ireg_q;
  assign bus.wc_o    = wreg_q;
  assign bus.valid_o = valid_q;
  assign bus.busy_o  = busy_q;
  assign bus.done_o  = done_q;
  assign bus.sat_o   = sat_q;

endmodule

// File: tb/tb_pe_m_seq.sv
// Directed bench for pe_m_seq: GEMM MAC, unary Horner iteration, saturation,
// N=0, mid-op reset and start/valid priority.
module tb_pe_m_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  pe_m_seq_if #(.MUL_BW(16), .ACC_BW(32), .ITER_W(4)) bus ();

  pe_m_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.mode_i = 2'b00; bus.start_i = 1'b0; bus.iter_num_i = '0; bus.valid_i = 1'b0;
    bus.mac_i = '0; bus.var_i = '0; bus.x_i = '0; bus.wc_i = '0; bus.o_i = '0;
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if (bus.mac_o !== 32'h0 || bus.o_o !== 32'h0) begin
      errors++; $display("FAIL reset_oreg: got %h/%h exp 0", bus.mac_o, bus.o_o);
    end
    checks++;
    if ({bus.var_o, bus.x_o, bus.wc_o} !== 48'h0) begin
      errors++; $display("FAIL reset_regs: got %h %h %h exp 0", bus.var_o, bus.x_o, bus.wc_o);
    end
    checks++;
    if ({bus.valid_o, bus.busy_o, bus.done_o, bus.sat_o} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b exp 0000",
                         {bus.valid_o, bus.busy_o, bus.done_o, bus.sat_o});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_gemm();
    bus.mode_i = 2'b00; bus.wc_i = 16'h0800; bus.x_i = 16'h0C00; bus.var_i = 16'h1234;
    bus.o_i = 32'h0010_0000; bus.valid_i = 1'b1;
    tick();
    bus.valid_i = 1'b0;
    checks++;
    if (bus.valid_o !== 1'b0) begin
      errors++; $display("FAIL gemm_early_valid: got %b exp 0", bus.valid_o);
    end
    checks++;
    if ({bus.wc_o, bus.x_o, bus.var_o} !== {16'h0800, 16'h0C00, 16'h1234}) begin
      errors++; $display("FAIL gemm_passthru: got %h %h %h exp 0800 0c00 1234",
                         bus.wc_o, bus.x_o, bus.var_o);
    end
    tick();
    checks++;
    if (bus.valid_o !== 1'b1 || bus.mac_o !== 32'h0070_0000 || bus.o_o !== 32'h0070_0000) begin
      errors++; $display("FAIL gemm_result: got v=%b %h/%h exp v=1 00700000",
                         bus.valid_o, bus.mac_o, bus.o_o);
    end
    tick();
    checks++;
    if (bus.valid_o !== 1'b0 || bus.mac_o !== 32'h0070_0000) begin
      errors++; $display("FAIL gemm_hold: got v=%b %h exp v=0 00700000", bus.valid_o, bus.mac_o);
    end
  endtask

  task automatic test_back_to_back();
    bus.wc_i = 16'hFC00; bus.x_i = 16'h0800; bus.valid_i = 1'b1;
    tick();
    bus.o_i = 32'h0; bus.wc_i = 16'h0200; bus.x_i = 16'h0200;
    tick();
    bus.o_i = 32'h0010_0000; bus.valid_i = 1'b0;
    checks++;
    if (bus.valid_o !== 1'b1 || bus.mac_o !== 32'hFFE0_0000) begin
      errors++; $display("FAIL b2b_first: got v=%b %h exp v=1 ffe00000", bus.valid_o, bus.mac_o);
    end
    tick();
    checks++;
    if (bus.valid_o !== 1'b1 || bus.mac_o !== 32'h0014_0000) begin
      errors++; $display("FAIL b2b_second: got v=%b %h exp v=1 00140000", bus.valid_o, bus.mac_o);
    end
    tick();
    checks++;
    if (bus.valid_o !== 1'b0) begin
      errors++; $display("FAIL b2b_end: got v=%b exp 0", bus.valid_o);
    end
  endtask

  task automatic test_unary_exp();
    logic [31:0] exp_o;
    bus.mode_i = 2'b10; bus.start_i = 1'b1; bus.mac_i = 32'h0010_0000;
    bus.var_i = 16'h0400; bus.wc_i = 16'h0400; bus.iter_num_i = 4'd3;
    tick();
    // Held start with a different seed must be ignored while busy.
    bus.mode_i = 2'b01; bus.mac_i = 32'h0BAD_0000; bus.iter_num_i = 4'd1;
    checks++;
    if (bus.busy_o !== 1'b1 || bus.done_o !== 1'b0 || bus.mac_o !== 32'h0010_0000 ||
        bus.var_o !== 16'h0400) begin
      errors++; $display("FAIL exp_start: got busy=%b done=%b o=%h v=%h exp 1 0 00100000 0400",
                         bus.busy_o, bus.done_o, bus.mac_o, bus.var_o);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      exp_o = 32'(k + 1) << 20;
      checks++;
      if (bus.mac_o !== exp_o || bus.done_o !== (k == 3) || bus.busy_o !== 1'b1) begin
        errors++; $display("FAIL exp_step%0d: got o=%h done=%b busy=%b exp o=%h done=%b busy=1",
                           k, bus.mac_o, bus.done_o, bus.busy_o, exp_o, (k == 3));
      end
    end
    bus.start_i = 1'b0;
    checks++;
    if (bus.sat_o !== 1'b0) begin
      errors++; $display("FAIL exp_sat: got %b exp 0", bus.sat_o);
    end
    tick();
    checks++;
    if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.mac_o !== 32'h0040_0000) begin
      errors++; $display("FAIL exp_idle: got busy=%b done=%b o=%h exp 0 0 00400000",
                         bus.busy_o, bus.done_o, bus.mac_o);
    end
  endtask

  task automatic test_saturation();
    bus.mode_i = 2'b01; bus.start_i = 1'b1; bus.mac_i = 32'h7000_0000;
    bus.var_i = 16'h0400; bus.wc_i = 16'h0000; bus.iter_num_i = 4'd1;
    tick();
    bus.start_i = 1'b0;
    tick();
    checks++;
    if (bus.mac_o !== 32'h01FF_FC00 || bus.sat_o !== 1'b1 || bus.done_o !== 1'b1) begin
      errors++; $display("FAIL sat_pos: got o=%h sat=%b done=%b exp 01fffc00 1 1",
                         bus.mac_o, bus.sat_o, bus.done_o);
    end
    tick();
    bus.start_i = 1'b1; bus.mac_i = 32'h9000_0000;
    tick();
    bus.start_i = 1'b0;
    checks++;
    if (bus.sat_o !== 1'b0) begin
      errors++; $display("FAIL sat_clear: got %b exp 0", bus.sat_o);
    end
    tick();
    checks++;
    if (bus.mac_o !== 32'hFE00_0000 || bus.sat_o !== 1'b1) begin
      errors++; $display("FAIL sat_neg: got o=%h sat=%b exp fe000000 1", bus.mac_o, bus.sat_o);
    end
    tick();
  endtask

  task automatic test_n_zero();
    bus.mode_i = 2'b11; bus.start_i = 1'b1; bus.mac_i = 32'h1234_5678; bus.iter_num_i = 4'd0;
    tick();
    bus.mac_i = 32'h0000_0ABC;
    checks++;
    if (bus.done_o !== 1'b1 || bus.busy_o !== 1'b1 || bus.mac_o !== 32'h1234_5678 ||
        bus.sat_o !== 1'b0) begin
      errors++; $display("FAIL nzero_done: got done=%b busy=%b o=%h sat=%b exp 1 1 12345678 0",
                         bus.done_o, bus.busy_o, bus.mac_o, bus.sat_o);
    end
    tick();
    bus.start_i = 1'b0;
    checks++;
    if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.mac_o !== 32'h1234_5678) begin
      errors++; $display("FAIL nzero_busy_start: got done=%b busy=%b o=%h exp 0 0 12345678",
                         bus.done_o, bus.busy_o, bus.mac_o);
    end
  endtask

  task automatic test_reset_mid();
    int seen_done;
    bus.mode_i = 2'b10; bus.start_i = 1'b1; bus.mac_i = 32'h0010_0000;
    bus.var_i = 16'h0400; bus.wc_i = 16'h0400; bus.iter_num_i = 4'd5;
    tick();
    bus.start_i = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.mac_o !== 32'h0 || bus.var_o !== 16'h0 ||
        {bus.busy_o, bus.done_o, bus.valid_o, bus.sat_o} !== 4'b0000) begin
      errors++; $display("FAIL rstmid_async: got o=%h v=%h flags=%b exp 0",
                         bus.mac_o, bus.var_o, {bus.busy_o, bus.done_o, bus.valid_o, bus.sat_o});
    end
    tick();
    rst_n = 1'b1;
    seen_done = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.done_o === 1'b1 || bus.busy_o === 1'b1) seen_done++;
    end
    checks++;
    if (seen_done != 0 || bus.mac_o !== 32'h0) begin
      errors++; $display("FAIL rstmid_abort: got busy/done cycles=%0d o=%h exp 0 0",
                         seen_done, bus.mac_o);
    end
  endtask

  task automatic test_acc_sat();
    logic [31:0] exp_o;
    logic        exp_s;
`ifdef ACC_SAT_EN
    exp_o = 32'h7FFF_FFFF; exp_s = 1'b1;
`else
    exp_o = 32'h800F_FFFF; exp_s = 1'b0;
`endif
    bus.mode_i = 2'b00; bus.wc_i = 16'h0400; bus.x_i = 16'h0400; bus.o_i = 32'h7FFF_FFFF;
    bus.valid_i = 1'b1;
    tick();
    bus.valid_i = 1'b0;
    tick();
    checks++;
    if (bus.mac_o !== exp_o || bus.sat_o !== exp_s || bus.valid_o !== 1'b1) begin
      errors++; $display("FAIL acc_sat: got o=%h sat=%b v=%b exp %h %b 1",
                         bus.mac_o, bus.sat_o, bus.valid_o, exp_o, exp_s);
    end
    tick();
  endtask

  task automatic test_start_vs_valid();
    bus.mode_i = 2'b01; bus.start_i = 1'b1; bus.valid_i = 1'b1; bus.iter_num_i = 4'd0;
    bus.wc_i = 16'h0C00; bus.x_i = 16'h0C00; bus.var_i = 16'h0800; bus.mac_i = 32'h0030_0000;
    tick();
    bus.start_i = 1'b0; bus.valid_i = 1'b0;
    checks++;
    if (bus.done_o !== 1'b1 || bus.mac_o !== 32'h0030_0000 || bus.x_o !== 16'h0400 ||
        bus.wc_o !== 16'h0400 || bus.var_o !== 16'h0800) begin
      errors++; $display("FAIL start_wins: got done=%b o=%h x=%h w=%h v=%h exp 1 00300000 0400 0400 0800",
                         bus.done_o, bus.mac_o, bus.x_o, bus.wc_o, bus.var_o);
    end
    tick();
    checks++;
    if (bus.valid_o !== 1'b0 || bus.mac_o !== 32'h0030_0000) begin
      errors++; $display("FAIL start_wins_nogemm: got v=%b o=%h exp 0 00300000",
                         bus.valid_o, bus.mac_o);
    end
  endtask

  initial begin
    test_reset();
    test_gemm();
    test_back_to_back();
    test_unary_exp();
    test_saturation();
    test_n_zero();
    test_reset_mid();
    test_acc_sat();
    test_start_vs_valid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
